// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: architectural register indices and default widths.
package mips_pkg;
  localparam int REG_ZERO   = 0;
  localparam int REG_V0     = 2;
  localparam int REG_A0     = 4;
  localparam int REG_RA     = 31;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: write, link, issue and packed read ports plus debug taps.
interface regfile_mp_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
);
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       link_en;
  logic [DATA_W-1:0]          link_data;
  logic                       issue_en;
  logic [ADDR_W-1:0]          issue_addr;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [DATA_W-1:0]          dbg_v0;
  logic [DATA_W-1:0]          dbg_a0;
  logic [DATA_W-1:0]          dbg_ra;

  modport master (
    output wr_en, wr_addr, wr_data, link_en, link_data, issue_en, issue_addr, rd_addr,
    input  rd_data, rd_busy, dbg_v0, dbg_a0, dbg_ra
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, link_en, link_data, issue_en, issue_addr, rd_addr,
    output rd_data, rd_busy, dbg_v0, dbg_a0, dbg_ra
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending busy vector: writes clear, issues set, a same-cycle issue beats the clear.
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_ok_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic                   lnk_ok_i,
  input  logic                   issue_en_i,
  input  logic [ADDR_W-1:0]      issue_addr_i,
  output logic [2**ADDR_W-1:0]   busy_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wr_ok_i) busy_d[wr_addr_i] = 1'b0;
    if (lnk_ok_i) busy_d[LINK_A] = 1'b0;
    if (issue_en_i) busy_d[issue_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with link write path, optional bypass and busy scoreboard.
module regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int LINK_REG = REG_RA
) (
  input logic         clock,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              gen_ok, lnk_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_busy_w;

  // Link write owns LINK_REG; a colliding general write is dropped.
  assign lnk_ok = bus.link_en && (LINK_A != ZERO_A);
  assign gen_ok = bus.wr_en && (bus.wr_addr != ZERO_A) && !(lnk_ok && bus.wr_addr == LINK_A);

  always_comb begin
    regs_d = regs_q;
    if (gen_ok) regs_d[bus.wr_addr] = bus.wr_data;
    if (lnk_ok) regs_d[LINK_A] = bus.link_data;
  end

  always_ff @(posedge clock) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W), .LINK_REG(LINK_REG)) u_sb (
    .clock        (clock),
    .reset        (reset),
    .wr_ok_i      (gen_ok),
    .wr_addr_i    (bus.wr_addr),
    .lnk_ok_i     (lnk_ok),
    .issue_en_i   (bus.issue_en),
    .issue_addr_i (bus.issue_addr),
    .busy_o       (busy)
  );

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic lnk_hit, wr_hit, reissue;
    rd_data_w = '0;
    rd_busy_w = '0;
    ra = '0;
    lnk_hit = 1'b0;
    wr_hit = 1'b0;
    reissue = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra      = bus.rd_addr[k*ADDR_W +: ADDR_W];
      lnk_hit = (BYPASS != 0) && lnk_ok && (ra == LINK_A);
      wr_hit  = (BYPASS != 0) && gen_ok && (ra == bus.wr_addr);
      reissue = bus.issue_en && (bus.issue_addr == ra);
      if (ra == ZERO_A)  rd_data_w[k*DATA_W +: DATA_W] = '0;
      else if (lnk_hit)  rd_data_w[k*DATA_W +: DATA_W] = bus.link_data;
      else if (wr_hit)   rd_data_w[k*DATA_W +: DATA_W] = bus.wr_data;
      else               rd_data_w[k*DATA_W +: DATA_W] = regs_q[ra];
      // An in-flight writeback retires the hazard unless a newer producer issues now.
      rd_busy_w[k] = busy[ra] && !((lnk_hit || wr_hit) && !reissue);
    end
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;
  assign bus.dbg_v0  = regs_q[ADDR_W'(REG_V0)];
  assign bus.dbg_a0  = regs_q[ADDR_W'(REG_A0)];
  assign bus.dbg_ra  = regs_q[ADDR_W'(REG_RA)];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing and a non-bypassing instance share one stimulus stream.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clock = 1'b0;
  logic reset;
  int   ntotal = 0;
  int   npass  = 0;
  int   nfail  = 0;

  always #5 clock = ~clock;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

  assign bus_n.wr_en      = bus_b.wr_en;
  assign bus_n.wr_addr    = bus_b.wr_addr;
  assign bus_n.wr_data    = bus_b.wr_data;
  assign bus_n.link_en    = bus_b.link_en;
  assign bus_n.link_data  = bus_b.link_data;
  assign bus_n.issue_en   = bus_b.issue_en;
  assign bus_n.issue_addr = bus_b.issue_addr;
  assign bus_n.rd_addr    = bus_b.rd_addr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .LINK_REG(31)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .LINK_REG(31)) dut_n (
    .clock (clock),
    .reset (reset),
    .bus   (bus_n)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_b.wr_en      = 1'b0;
    bus_b.wr_addr    = '0;
    bus_b.wr_data    = '0;
    bus_b.link_en    = 1'b0;
    bus_b.link_data  = '0;
    bus_b.issue_en   = 1'b0;
    bus_b.issue_addr = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    bus_b.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = AW'(a);
    bus_b.wr_data = d;
  endtask

  function automatic logic [DW-1:0] rdb(input int k);
    return bus_b.rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rdn(input int k);
    return bus_n.rd_data[k*DW +: DW];
  endfunction

  initial begin
    idle();
    rd(0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Cleared state on every index and port
    for (int i = 0; i < 32; i++) begin
      rd(i, i);
      #1;
      chk($sformatf("reset_rd_%0d", i), {bus_b.rd_busy, rdb(1), rdb(0)}, 64'd0);
    end
    chk("reset_dbg", {bus_b.dbg_v0, bus_b.dbg_a0}, 64'd0);
    chk("reset_dbg_ra", {32'd0, bus_b.dbg_ra}, 64'd0);

    // Register 0 ignores writes and issues, even through bypass
    rd(0, 0);
    wr(0, 32'hDEADBEEF);
    bus_b.issue_en   = 1'b1;
    bus_b.issue_addr = 5'd0;
    #1;
    chk("r0_bypass", {32'd0, rdb(0)}, 64'd0);
    tick();
    idle();
    #1;
    chk("r0_data", {rdb(1), rdb(0)}, 64'd0);
    chk("r0_busy", {62'd0, bus_b.rd_busy}, 64'd0);

    // Same-cycle bypass versus next-cycle visibility
    rd(0, 9);
    wr(9, 32'h12345678);
    #1;
    chk("byp_on_same", {32'd0, rdb(1)}, {32'd0, 32'h12345678});
    chk("byp_off_same", {32'd0, rdn(1)}, 64'd0);
    tick();
    idle();
    #1;
    chk("byp_off_next", {32'd0, rdn(1)}, {32'd0, 32'h12345678});
    chk("byp_on_next", {32'd0, rdb(1)}, {32'd0, 32'h12345678});

    // Link write beats a general write to r31
    rd(31, 31);
    bus_b.link_en   = 1'b1;
    bus_b.link_data = 32'h00400010;
    wr(31, 32'h5);
    #1;
    chk("link_byp", {32'd0, rdb(0)}, {32'd0, 32'h00400010});
    tick();
    idle();
    #1;
    chk("link_prio_b", {32'd0, bus_b.dbg_ra}, {32'd0, 32'h00400010});
    chk("link_prio_n", {32'd0, bus_n.dbg_ra}, {32'd0, 32'h00400010});

    // Non-colliding link and general writes both land
    rd(8, 31);
    bus_b.link_en   = 1'b1;
    bus_b.link_data = 32'h00400020;
    wr(8, 32'h5);
    tick();
    idle();
    #1;
    chk("link_both_ra", {32'd0, bus_n.dbg_ra}, {32'd0, 32'h00400020});
    chk("link_both_r8", {rdn(1), rdn(0)}, {32'h00400020, 32'h5});

    // Debug taps on v0 and a0
    wr(2, 32'hAAAA0002);
    tick();
    wr(4, 32'hBBBB0004);
    tick();
    idle();
    #1;
    chk("dbg_v0_a0", {bus_b.dbg_v0, bus_b.dbg_a0}, {32'hAAAA0002, 32'hBBBB0004});

    // Scoreboard: set, set-beats-clear, clear
    rd(10, 10);
    bus_b.issue_en   = 1'b1;
    bus_b.issue_addr = 5'd10;
    #1;
    chk("sb_not_yet", {62'd0, bus_n.rd_busy}, 64'd0);
    tick();
    idle();
    #1;
    chk("sb_set_b", {62'd0, bus_b.rd_busy}, 64'd3);
    chk("sb_set_n", {62'd0, bus_n.rd_busy}, 64'd3);
    tick();
    wr(10, 32'h0000A0A0);
    bus_b.issue_en   = 1'b1;
    bus_b.issue_addr = 5'd10;
    #1;
    chk("sb_reissue_byp", {62'd0, bus_b.rd_busy}, 64'd3);
    tick();
    idle();
    #1;
    chk("sb_still_b", {62'd0, bus_b.rd_busy}, 64'd3);
    chk("sb_still_n", {62'd0, bus_n.rd_busy}, 64'd3);
    wr(10, 32'h0000B0B0);
    #1;
    chk("sb_wb_byp_b", {62'd0, bus_b.rd_busy}, 64'd0);
    chk("sb_wb_byp_n", {62'd0, bus_n.rd_busy}, 64'd3);
    tick();
    idle();
    #1;
    chk("sb_clr", {60'd0, bus_b.rd_busy, bus_n.rd_busy}, 64'd0);
    chk("sb_data", {32'd0, rdn(0)}, {32'd0, 32'h0000B0B0});

    // Reset during an outstanding issue, then a normal writeback
    bus_b.issue_en   = 1'b1;
    bus_b.issue_addr = 5'd12;
    tick();
    idle();
    wr(12, 32'h00001212);
    tick();
    wr(13, 32'h00001313);
    tick();
    idle();
    bus_b.issue_en   = 1'b1;
    bus_b.issue_addr = 5'd12;
    tick();
    idle();
    rd(12, 13);
    #1;
    chk("mid_pre", {bus_n.rd_busy[1:0], rdn(1)}, {2'b01, 32'h00001313});
    reset = 1'b1;
    wr(13, 32'h00009999);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("mid_r13", {32'd0, rdn(1)}, 64'd0);
    chk("mid_r12", {32'd0, rdn(0)}, 64'd0);
    chk("mid_busy", {60'd0, bus_b.rd_busy, bus_n.rd_busy}, 64'd0);
    chk("mid_dbg", {bus_n.dbg_ra, bus_n.dbg_v0}, 64'd0);
    wr(12, 32'h00007777);
    tick();
    idle();
    #1;
    chk("mid_wb", {30'd0, bus_n.rd_busy, rdn(0)}, {34'd0, 32'h00007777});

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a write-pending scoreboard. It is the next-generation register file for the MIPS datapath: configurable width, depth and read-port count; a synchronous active-high reset that clears all state; posedge writes with optional same-cycle write-to-read bypass; a dedicated link-register write path for `jal`; and per-register busy bits so the decode stage can detect RAW hazards on multi-cycle producers.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: index width. Depth is 2^ADDR_W.
- `NUM_RD`, default 2: number of read ports, 1–4.
- `BYPASS`, default 1: when 1, a read of the register being written this cycle returns the write data.
- `LINK_REG`, default 31: index written by the link path.

Ports (clock and reset first):
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Clears every register and every busy bit.
- `wr_en`  in  1: general write enable.
- `wr_addr`  in  ADDR_W: general write index.
- `wr_data`  in  DATA_W: general write data.
- `link_en`  in  1: link write enable. Writes `link_data` to `LINK_REG`.
- `link_data`  in  DATA_W: return address (PC+4 or PC+8), supplied by the fetch stage.
- `issue_en`  in  1: an instruction with a pending destination has issued.
- `issue_addr`  in  ADDR_W: that instruction's destination index.
- `rd_addr`  in  NUM_RD*ADDR_W: read indices, packed. Port k occupies bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W: read data, packed the same way.
- `rd_busy`  out  NUM_RD: busy bit of each addressed register.
- `dbg_v0`, `dbg_a0`, `dbg_ra`  out  DATA_W: continuous taps on registers 2, 4 and 31.

## Operation
- Register 0:
  - Reads always return 0 and are never busy.
  - Writes and issues targeting register 0 are ignored.
- Reads are combinational.
  - `rd_data[k]` is the content of `rd_addr[k]`.
  - When `BYPASS=1`, a read whose index equals an index being written in the same cycle returns the incoming data instead.
- Write priority in one cycle:
  - If `link_en` is set and `wr_en` targets `LINK_REG`, the link write wins and the general write is dropped.
  - Otherwise both writes commit.
- Scoreboard, `busy[i]`, updated per cycle:
  - A write to i (general or link) clears `busy[i]`.
  - `issue_en` with i sets `busy[i]`.
  - If the set and the clear hit the same i in the same cycle, the set wins, because a newer producer exists.
- `rd_busy[k]` is `busy[rd_addr[k]]`.
  - When `BYPASS=1`, it reads 0 if that register is being written this cycle and not re-issued in the same cycle.
- Reset:
  - Takes precedence over writes and issues in the same cycle.
  - All registers read 0 and all busy bits read 0 from the next cycle on.

## Timing
- Write latency: data committed on edge N is visible without bypass from cycle N+1. With bypass it is visible in cycle N itself.
- Busy set latency: `issue_en` asserted in cycle N shows as busy from cycle N+1.
- Reset values:
  - `rd_data` = 0, `rd_busy` = 0, all `dbg_*` = 0.
  - Outputs are combinational, so these values follow the cleared state.
- Reset asserted mid-stream (e.g. during an outstanding issue): the busy bit is cleared, and the later writeback is accepted normally.
- No X propagation: the register array is fully initialised by reset, with no `initial` blocks.

## Structure
- Shared package `mips_pkg` holds:
  - Register index constants `REG_ZERO`=0, `REG_V0`=2, `REG_A0`=4, `REG_RA`=31.
  - Default widths `DATA_W_DEF`=32 and `ADDR_W_DEF`=5.
- Sub-module `regfile_scoreboard`:
  - Contains the busy vector and its set/clear/reset logic.
  - Exposes the busy vector to the top level, which performs the per-port muxing.

## Test plan
- Reset then read: assert reset for 2 cycles, then read all 32 indices on every port → all 0, all `rd_busy` 0, `dbg_*` 0.
- Register 0: write 0xDEADBEEF to register 0 and issue to register 0 → reads of register 0 return 0, `rd_busy` 0.
- Write and bypass (`BYPASS=1`): in one cycle write 0x12345678 to register 9 while port 1 reads register 9 → `rd_data[1]` is 0x12345678 in that cycle; with `BYPASS=0` it is the old value, then 0x12345678 next cycle.
- Link priority: `link_en` with 0x00400010 and `wr_en` to register 31 with 0x5 in the same cycle → `dbg_ra` is 0x00400010. Repeat with `wr_addr`=8 → both registers written.
- Scoreboard: issue register 10 at cycle 1 → `rd_busy` set for register 10 from cycle 2. Write register 10 and issue register 10 in the same cycle 5 → still busy at cycle 6. Write only at cycle 7 → clear at cycle 8.
- Reset mid-operation: issue register 12 and write registers 12 and 13, then assert reset while `wr_en` targets register 13 → register 13 reads 0 and `busy[12]` is 0 after reset.
